// File: rtl/dac8728_pkg.sv
// Shared types and widths for the DAC8728 parallel-interface controllers.
package dac8728_pkg;

  localparam int DAC_ADDR_W = 5;
  localparam int DAC_DATA_W = 16;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } rd_state_e;

endpackage

// File: rtl/dac8728_reader_if.sv
// Request/response handshake between a register-read client and dac8728_reader.
interface dac8728_reader_if;
  import dac8728_pkg::*;

  logic                         req_valid;
  logic                         req_ready;
  logic [DAC_ADDR_W-1:0]        req_addr;
  logic                         req_check;
  logic signed [DAC_DATA_W-1:0] req_expect;
  logic                         rsp_valid;
  logic [DAC_ADDR_W-1:0]        rsp_addr;
  logic signed [DAC_DATA_W-1:0] rsp_data;
  logic                         rsp_mismatch;

  modport master (
    output req_valid, req_addr, req_check, req_expect,
    input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_mismatch
  );

  modport slave (
    input  req_valid, req_addr, req_check, req_expect,
    output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_mismatch
  );

endinterface

// File: rtl/dac8728_reader.sv
// DAC8728 readback controller: one timed CS-low read cycle per request,
// returning the sampled word with an optional compare against an expected value.
module dac8728_reader
  import dac8728_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dac8728_reader_if.slave       host,
  input  logic                  err_clr,
  output logic [15:0]           err_cnt,
  output logic                  busy,
  output logic                  dac_re_wr,
  output logic                  dac_cs_n,
  output logic [DAC_ADDR_W-1:0] dac_add,
  input  logic [DAC_DATA_W-1:0] dac_data_i
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [15:0]      ERR_MAX   = 16'hFFFF;

  rd_state_e                    state_r, state_nxt_s;
  logic [CNT_W-1:0]             cnt_r, cnt_nxt_s;
  logic                         accept_s, sample_s;
  logic [DAC_ADDR_W-1:0]        addr_r, dac_add_r, rsp_addr_r;
  logic                         check_r;
  logic signed [DAC_DATA_W-1:0] expect_r, rsp_data_r;
  logic                         req_ready_r, busy_r, cs_n_r, re_wr_r;
  logic                         rsp_valid_r, rsp_mismatch_r;
  logic [15:0]                  err_cnt_r;

  // Next-state and shared phase-counter decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    sample_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (host.req_valid && req_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = SETUP;
          cnt_nxt_s   = SETUP_LD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = STROBE;
          cnt_nxt_s   = STROBE_LD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt_r == CNT_ZERO) begin
          sample_s    = 1'b1;
          state_nxt_s = HOLD;
          cnt_nxt_s   = HOLD_LD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = RESP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and pin/handshake registers, all decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      cs_n_r      <= 1'b1;
      re_wr_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      req_ready_r <= (state_nxt_s == IDLE);
      busy_r      <= (state_nxt_s != IDLE);
      cs_n_r      <= (state_nxt_s != STROBE);
      re_wr_r     <= 1'b1;
      rsp_valid_r <= (state_nxt_s == RESP);
    end
  end

  // Request latch, bus sample and response fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r         <= {DAC_ADDR_W{1'b0}};
      check_r        <= 1'b0;
      expect_r       <= {DAC_DATA_W{1'b0}};
      dac_add_r      <= {DAC_ADDR_W{1'b0}};
      rsp_addr_r     <= {DAC_ADDR_W{1'b0}};
      rsp_data_r     <= {DAC_DATA_W{1'b0}};
      rsp_mismatch_r <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r    <= host.req_addr;
        check_r   <= host.req_check;
        expect_r  <= host.req_expect;
        dac_add_r <= host.req_addr;
      end
      if (sample_s) begin
        rsp_data_r <= dac_data_i;
      end
      if (state_nxt_s == RESP) begin
        rsp_addr_r <= addr_r;
      end
      // HOLD is at least one cycle, so rsp_data_r is already settled here
      rsp_mismatch_r <= (state_nxt_s == RESP) && check_r && (rsp_data_r != expect_r);
    end
  end

  // Saturating mismatch counter; a clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= 16'h0000;
    end else if (err_clr) begin
      err_cnt_r <= 16'h0000;
    end else if (rsp_valid_r && rsp_mismatch_r && (err_cnt_r != ERR_MAX)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

  assign host.req_ready    = req_ready_r;
  assign host.rsp_valid    = rsp_valid_r;
  assign host.rsp_addr     = rsp_addr_r;
  assign host.rsp_data     = rsp_data_r;
  assign host.rsp_mismatch = rsp_mismatch_r;
  assign err_cnt           = err_cnt_r;
  assign busy              = busy_r;
  assign dac_re_wr         = re_wr_r;
  assign dac_cs_n          = cs_n_r;
  assign dac_add           = dac_add_r;

endmodule

// File: tb/tb_dac8728_reader.sv
// Bench for dac8728_reader: three timing configurations driven in parallel and
// compared every cycle against a cycle-position reference model.
module tb_dac8728_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_check, err_clr, err_preload;
  logic [4:0]  req_addr;
  logic [15:0] req_expect, dac_data;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rsp_seen = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // cfg[0]: defaults, cfg[1]: STROBE_CYC=1, cfg[2]: SETUP_CYC=HOLD_CYC=1
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int S   = (g == 2) ? 1 : 2;
    localparam int ST  = (g == 1) ? 1 : 4;
    localparam int H   = (g == 2) ? 1 : 2;
    localparam int RSP = S + ST + H + 1;

    dac8728_reader_if bus_if ();
    logic [15:0] err_cnt;
    logic        busy, re_wr, cs_n;
    logic [4:0]  add;

    assign bus_if.req_valid  = req_valid;
    assign bus_if.req_addr   = req_addr;
    assign bus_if.req_check  = req_check;
    assign bus_if.req_expect = req_expect;

    dac8728_reader #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .host       (bus_if),
      .err_clr    (err_clr),
      .err_cnt    (err_cnt),
      .busy       (busy),
      .dac_re_wr  (re_wr),
      .dac_cs_n   (cs_n),
      .dac_add    (add),
      .dac_data_i (dac_data)
    );

    // pos = cycle index since accept (1 = first SETUP cycle), 0 when idle
    int          pos;
    logic        ready_m, chk_m;
    logic [4:0]  add_m;
    logic [15:0] exp_m, data_m, err_m;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        pos <= 0; ready_m <= 1'b0; chk_m <= 1'b0; add_m <= 5'd0;
        exp_m <= 16'd0; data_m <= 16'd0; err_m <= 16'd0;
      end else begin
        if (err_clr)
          err_m <= 16'd0;
        else if (pos == RSP && chk_m && data_m != exp_m)
          err_m <= (err_m == 16'hFFFF) ? 16'hFFFF : err_m + 16'd1;
        else if (err_preload && g == 0)
          err_m <= 16'hFFFE;
        if (pos == 0) begin
          if (ready_m && req_valid) begin
            pos <= 1; ready_m <= 1'b0;
            add_m <= req_addr; chk_m <= req_check; exp_m <= req_expect;
          end else begin
            ready_m <= 1'b1;
          end
        end else begin
          if (pos == S + ST) data_m <= dac_data;
          if (pos == RSP) begin
            pos <= 0; ready_m <= 1'b1;
          end else begin
            pos <= pos + 1;
          end
        end
      end
    end

    always @(posedge clk) begin
      #1;
      if (rst) begin
        check_val($sformatf("c%0d_rst_ready", g), bus_if.req_ready, 0);
        check_val($sformatf("c%0d_rst_rsp_valid", g), bus_if.rsp_valid, 0);
        check_val($sformatf("c%0d_rst_rsp_addr", g), bus_if.rsp_addr, 0);
        check_val($sformatf("c%0d_rst_rsp_data", g), $unsigned(bus_if.rsp_data), 0);
        check_val($sformatf("c%0d_rst_rsp_mism", g), bus_if.rsp_mismatch, 0);
        check_val($sformatf("c%0d_rst_err_cnt", g), err_cnt, 0);
        check_val($sformatf("c%0d_rst_busy", g), busy, 0);
        check_val($sformatf("c%0d_rst_re_wr", g), re_wr, 1);
        check_val($sformatf("c%0d_rst_cs_n", g), cs_n, 1);
        check_val($sformatf("c%0d_rst_add", g), add, 0);
      end else begin
        check_val($sformatf("c%0d_ready", g), bus_if.req_ready, ready_m);
        check_val($sformatf("c%0d_busy", g), busy, pos != 0);
        check_val($sformatf("c%0d_cs_n", g), cs_n, !(pos > S && pos <= S + ST));
        check_val($sformatf("c%0d_rsp_valid", g), bus_if.rsp_valid, pos == RSP);
        check_val($sformatf("c%0d_add", g), add, add_m);
        check_val($sformatf("c%0d_re_wr", g), re_wr, 1);
        check_val($sformatf("c%0d_err_cnt", g), err_cnt, err_m);
        if (pos == RSP) begin
          check_val($sformatf("c%0d_rsp_addr", g), bus_if.rsp_addr, add_m);
          check_val($sformatf("c%0d_rsp_data", g), $unsigned(bus_if.rsp_data), data_m);
          check_val($sformatf("c%0d_rsp_mism", g), bus_if.rsp_mismatch, chk_m && (data_m != exp_m));
        end
      end
    end
  end

  always @(negedge clk) if (cfg[0].bus_if.rsp_valid === 1'b1) rsp_seen <= rsp_seen + 1;

  // Returns the label of the accepting edge; leaves the caller at the negedge of cycle T+1
  task automatic wait_accept(output int t);
    t = -1;
    for (int n = 0; n < 64; n++) begin
      if (t < 0 && cfg[0].bus_if.req_ready === 1'b1 && req_valid) t = cyc + 1;
      @(negedge clk);
      if (t >= 0) break;
    end
    if (t < 0) check_val("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int t, output logic [15:0] d, output logic [4:0] a,
                          output logic m, output int low);
    t = -1; d = 16'd0; a = 5'd0; m = 1'b0; low = 0;
    for (int n = 0; n < 64; n++) begin
      if (t < 0 && cfg[0].bus_if.rsp_valid === 1'b1) begin
        t = cyc + 1; d = cfg[0].bus_if.rsp_data; a = cfg[0].bus_if.rsp_addr;
        m = cfg[0].bus_if.rsp_mismatch;
      end else if (t < 0 && cfg[0].cs_n === 1'b0) begin
        low++;
      end
      @(negedge clk);
      if (t >= 0) break;
    end
    if (t < 0) check_val("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [4:0] addr, input logic chk, input logic [15:0] exp,
                         input logic [15:0] data, output int lat, output logic [15:0] d,
                         output logic [4:0] a, output logic m, output int low);
    int t_acc, t_rsp;
    req_addr = addr; req_check = chk; req_expect = exp; dac_data = data; req_valid = 1'b1;
    wait_accept(t_acc);
    req_valid = 1'b0;
    wait_rsp(t_rsp, d, a, m, low);
    lat = t_rsp - t_acc;
  endtask

  initial begin
    int          lat, low, t1, t2, t3, s0;
    logic [15:0] d;
    logic [4:0]  a;
    logic        m;

    req_valid = 1'b0; req_addr = 5'd0; req_check = 1'b0; req_expect = 16'd0;
    err_clr = 1'b0; err_preload = 1'b0; dac_data = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_read(5'h07, 1'b0, 16'h0000, 16'h7FFF, lat, d, a, m, low);
    check_val("single_latency", lat, 9);
    check_val("single_cs_low", low, 4);
    check_val("single_data", d, 16'h7FFF);
    check_val("single_addr", a, 5'h07);
    check_val("single_mism", m, 1'b0);

    do_read(5'h00, 1'b1, 16'h8180, 16'h8180, lat, d, a, m, low);
    check_val("cmp_match_mism", m, 1'b0);
    check_val("cmp_match_err", cfg[0].err_cnt, 16'd0);
    do_read(5'h00, 1'b1, 16'h8180, 16'h8181, lat, d, a, m, low);
    check_val("cmp_miss_mism", m, 1'b1);
    check_val("cmp_miss_err", cfg[0].err_cnt, 16'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_val("err_clr", cfg[0].err_cnt, 16'd0);

    // bus changes in the middle of the last STROBE cycle
    req_addr = 5'h11; req_check = 1'b0; dac_data = 16'h1111; req_valid = 1'b1;
    wait_accept(t1);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    dac_data = 16'h2222;
    wait_rsp(t2, d, a, m, low);
    check_val("sample_point", d, 16'h2222);

    s0 = rsp_seen;
    req_addr = 5'h1F; req_valid = 1'b1;
    wait_accept(t1);
    wait_accept(t2);
    wait_accept(t3);
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    check_val("b2b_spacing_1", t2 - t1, 10);
    check_val("b2b_spacing_2", t3 - t2, 10);
    check_val("b2b_rsp_count", rsp_seen - s0, 3);

    req_addr = 5'h0A; dac_data = 16'h5A5A; req_valid = 1'b1;
    wait_accept(t1);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("pre_rst_cs_n", cfg[0].cs_n, 1'b0);
    s0 = rsp_seen;
    rst = 1'b1;
    #1;
    check_val("rst_now_cs_n", cfg[0].cs_n, 1'b1);
    check_val("rst_now_busy", cfg[0].busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_rel_ready", cfg[0].bus_if.req_ready, 1'b1);
    repeat (12) @(negedge clk);
    check_val("rst_no_rsp", rsp_seen - s0, 0);
    do_read(5'h15, 1'b0, 16'h0000, 16'hC3C3, lat, d, a, m, low);
    check_val("post_rst_data", d, 16'hC3C3);
    check_val("post_rst_addr", a, 5'h15);

    err_preload = 1'b1;
    force cfg[0].u_dut.err_cnt_r = 16'hFFFE;
    @(negedge clk);
    release cfg[0].u_dut.err_cnt_r;
    err_preload = 1'b0;
    do_read(5'h03, 1'b1, 16'h0000, 16'h0001, lat, d, a, m, low);
    check_val("sat_reach", cfg[0].err_cnt, 16'hFFFF);
    do_read(5'h03, 1'b1, 16'h0000, 16'h0001, lat, d, a, m, low);
    check_val("sat_hold", cfg[0].err_cnt, 16'hFFFF);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 1) == 1);
      req_addr  = 5'($urandom_range(0, 31));
      req_check = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) dac_data = 16'($urandom);
      req_expect = ($urandom_range(0, 1) == 1) ? dac_data : 16'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
    end
    req_valid = 1'b0; err_clr = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
